uart_receiver: RTL and testbench

Serial-to-parallel UART receive stage: the consumer of the serial line driven by the team's UART transmitter. It resynchronises the asynchronous `i_rx` line, detects and validates the start bit, and samples 8 data bits LSB-first at mid-bit. It then checks the stop bit and presents the byte with a one-cycle valid strobe, or flags a framing error. Frame format is fixed at 8N1.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_sync.sv | 31 +++
 rtl/uart_receiver.sv | 133 +++++++++++++
 tb/tb_uart_receiver.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit sides.
package uart_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_DEFAULT_CLKS_PER_BIT = 104;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = i_d;
    sync_d = meta_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: start-bit validation, mid-bit sampling, stop-bit check.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_rx,
  output logic [UART_DATA_BITS-1:0] o_data,
  output logic                      o_valid,
  output logic                      o_frame_err,
  output logic                      o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int H  = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(UART_DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_cpb
    $error("uart_receiver: CLKS_PER_BIT must be >= 4");
  end

  logic rx_s;

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rx),
    .o_q   (rx_s)
  );

  rx_state_t                 state_d, state_q;
  logic [CW-1:0]             cnt_d, cnt_q;
  logic [2:0]                idx_d, idx_q;
  logic [UART_DATA_BITS-1:0] shift_d, shift_q;
  logic [UART_DATA_BITS-1:0] data_d, data_q;
  logic                      valid_d, valid_q;
  logic                      ferr_d, ferr_q;
  logic                      busy_d, busy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == IDX_LAST) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // A low stop bit may be a break; hold off start detection until the line recovers.
      WAIT_HIGH: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 and 104 clocks per bit.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx16 = 1'b1;
  logic       rx104 = 1'b1;
  logic [7:0] data16, data104;
  logic       valid16, valid104, ferr16, ferr104, busy16, busy104;

  always #5 clk = ~clk;

  uart_receiver #(.CLKS_PER_BIT(16)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_rx(rx16),
    .o_data(data16), .o_valid(valid16), .o_frame_err(ferr16), .o_busy(busy16)
  );

  uart_receiver #(.CLKS_PER_BIT(104)) dut104 (
    .i_clk(clk), .i_rst(rst), .i_rx(rx104),
    .o_data(data104), .o_valid(valid104), .o_frame_err(ferr104), .o_busy(busy104)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_c0;
  logic prev_valid = 1'b0;

  logic [7:0] vq_d[$];
  int         vq_c[$];
  int         fq_c[$];
  logic       ba_q[$];
  logic [7:0] vq104_d[$];
  int         fq104_c[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid16) begin
      vq_d.push_back(data16);
      vq_c.push_back(cyc);
    end
    if (ferr16) fq_c.push_back(cyc);
    if (prev_valid) ba_q.push_back(busy16);
    prev_valid <= valid16;
    if (valid104) vq104_d.push_back(data104);
    if (ferr104) fq104_c.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 0) rx16 = v;
    else rx104 = v;
  endtask

  // Called on a negedge; returns on the negedge ending the stop bit.
  task automatic send_frame(input int which, input logic [7:0] b, input logic stop, input int per);
    last_c0 = cyc;
    set_line(which, 1'b0);
    repeat (per) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_line(which, b[i]);
      repeat (per) @(negedge clk);
    end
    set_line(which, stop);
    repeat (per) @(negedge clk);
  endtask

  task automatic clear_q();
    vq_d.delete(); vq_c.delete(); fq_c.delete(); ba_q.delete();
  endtask

  initial begin
    int c0, nb;
    logic [7:0] exp_b[3];
    exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h55;

    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_data",  {24'd0, data16}, 32'h00);
    check("rst_valid", {31'd0, valid16}, 32'd0);
    check("rst_ferr",  {31'd0, ferr16}, 32'd0);
    check("rst_busy",  {31'd0, busy16}, 32'd0);
    repeat (5) @(negedge clk);

    // single byte
    clear_q();
    send_frame(0, 8'hA5, 1'b1, 16);
    c0 = last_c0;
    repeat (5) @(negedge clk);
    check("single_cnt",  vq_d.size(), 32'd1);
    if (vq_d.size() > 0) begin
      check("single_data", {24'd0, vq_d[0]}, 32'hA5);
      check("single_cyc",  vq_c[0], c0 + 155);
    end
    check("single_ferr", fq_c.size(), 32'd0);
    if (ba_q.size() > 0) check("single_busy_after", {31'd0, ba_q[0]}, 32'd0);
    else check("single_busy_after_seen", ba_q.size(), 32'd1);

    // back-to-back
    repeat (10) @(negedge clk);
    clear_q();
    send_frame(0, 8'h00, 1'b1, 16);
    c0 = last_c0;
    send_frame(0, 8'hFF, 1'b1, 16);
    send_frame(0, 8'h55, 1'b1, 16);
    repeat (5) @(negedge clk);
    check("b2b_cnt", vq_d.size(), 32'd3);
    if (vq_d.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("b2b_data%0d", i), {24'd0, vq_d[i]}, {24'd0, exp_b[i]});
        check($sformatf("b2b_cyc%0d", i), vq_c[i], c0 + 155 + 160 * i);
      end
    end
    check("b2b_ferr", fq_c.size(), 32'd0);

    // glitch
    repeat (10) @(negedge clk);
    clear_q();
    nb = 0;
    set_line(0, 1'b0);
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (i == 2) set_line(0, 1'b1);
      if (busy16) nb++;
    end
    check("glitch_valid", vq_d.size(), 32'd0);
    check("glitch_ferr",  fq_c.size(), 32'd0);
    check("glitch_busy_le9", {31'd0, (nb > 0 && nb <= 9)}, 32'd1);

    // framing error, break, then recovery
    clear_q();
    send_frame(0, 8'h3C, 1'b0, 16);
    c0 = last_c0;
    repeat (50) @(negedge clk);
    set_line(0, 1'b1);
    repeat (20) @(negedge clk);
    check("ferr_cnt", fq_c.size(), 32'd1);
    if (fq_c.size() > 0) check("ferr_cyc", fq_c[0], c0 + 155);
    check("ferr_no_valid", vq_d.size(), 32'd0);
    check("ferr_data_hold", {24'd0, data16}, 32'h55);
    clear_q();
    send_frame(0, 8'h81, 1'b1, 16);
    repeat (5) @(negedge clk);
    check("recov_cnt", vq_d.size(), 32'd1);
    if (vq_d.size() > 0) check("recov_data", {24'd0, vq_d[0]}, 32'h81);
    check("recov_ferr", fq_c.size(), 32'd0);

    // reset during data bit 3
    repeat (10) @(negedge clk);
    clear_q();
    fork
      send_frame(0, 8'hC3, 1'b1, 16);
      begin
        repeat (72) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_data",  {24'd0, data16}, 32'h00);
        check("mrst_valid", {31'd0, valid16}, 32'd0);
        check("mrst_ferr",  {31'd0, ferr16}, 32'd0);
        check("mrst_busy",  {31'd0, busy16}, 32'd0);
      end
    join
    check("mrst_no_strobe", vq_d.size() + fq_c.size(), 32'd0);
    // the still-low line restarts a bogus frame after reset; let it drain
    repeat (200) @(negedge clk);
    clear_q();
    send_frame(0, 8'h7E, 1'b1, 16);
    repeat (5) @(negedge clk);
    check("post_rst_cnt", vq_d.size(), 32'd1);
    if (vq_d.size() > 0) check("post_rst_data", {24'd0, vq_d[0]}, 32'h7E);
    check("post_rst_ferr", fq_c.size(), 32'd0);

    // +/-3% bit period at 104 clocks per bit
    vq104_d.delete(); fq104_c.delete();
    send_frame(1, 8'h00, 1'b1, 107);
    send_frame(1, 8'hFF, 1'b1, 101);
    send_frame(1, 8'h00, 1'b1, 101);
    send_frame(1, 8'hFF, 1'b1, 107);
    repeat (20) @(negedge clk);
    check("margin_cnt", vq104_d.size(), 32'd4);
    if (vq104_d.size() == 4) begin
      check("margin_00_slow", {24'd0, vq104_d[0]}, 32'h00);
      check("margin_ff_fast", {24'd0, vq104_d[1]}, 32'hFF);
      check("margin_00_fast", {24'd0, vq104_d[2]}, 32'h00);
      check("margin_ff_slow", {24'd0, vq104_d[3]}, 32'hFF);
    end
    check("margin_ferr", fq104_c.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
